// File: rtl/trigger_in_detector.sv
// External trigger input: two-flop synchronizer, consecutive-sample glitch filter,
// polarity-selectable edge detect and an IDLE/ARMED/HOLDOFF arming FSM with pulse counter.
module trigger_in_detector #(
   parameter int FILTER_LEN = 4,
   parameter int HOLD_W     = 16
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              Din,
   input  logic              EN,
   input  logic              Sel,
   input  logic              Mode,
   input  logic              Arm,
   input  logic [HOLD_W-1:0] Holdoff,
   output logic              Trig,
   output logic              Armed,
   output logic [15:0]       Trig_Count
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      HOLDOFF = 2'd2
   } state_t;

   localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);

   state_t            state_reg, state_next;
   logic              sync1_reg, sync2_reg;
   logic              level_reg, level_d_reg;
   logic [3:0]        filt_cnt_reg;
   logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic              trig_reg, trig_next;
   logic              armed_reg;
   logic [15:0]       trig_count_reg;
   logic              edge_det;

   // Level is accepted only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sync1_reg    <= 1'b0;
         sync2_reg    <= 1'b0;
         level_reg    <= 1'b0;
         level_d_reg  <= 1'b0;
         filt_cnt_reg <= 4'd0;
      end else begin
         sync1_reg   <= Din;
         sync2_reg   <= sync1_reg;
         level_d_reg <= level_reg;
         if (sync2_reg == level_reg) begin
            filt_cnt_reg <= 4'd0;
         end else if (filt_cnt_reg == FILT_LAST) begin
            level_reg    <= sync2_reg;
            filt_cnt_reg <= 4'd0;
         end else begin
            filt_cnt_reg <= filt_cnt_reg + 4'd1;
         end
      end
   end

   assign edge_det = Sel ? (level_d_reg & ~level_reg) : (level_reg & ~level_d_reg);

   always_comb begin
      state_next    = state_reg;
      hold_cnt_next = hold_cnt_reg;
      trig_next     = 1'b0;
      if (!EN) begin
         state_next    = IDLE;
         hold_cnt_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (Arm) state_next = ARMED;
            end
            ARMED: begin
               if (edge_det) begin
                  trig_next = 1'b1;
                  if (Mode) begin
                     state_next    = HOLDOFF;
                     hold_cnt_next = Holdoff;
                  end else begin
                     state_next = IDLE;
                  end
               end
            end
            HOLDOFF: begin
               if (hold_cnt_reg == '0) state_next = ARMED;
               else hold_cnt_next = hold_cnt_reg - HOLD_W'(1);
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Armed is registered from the next-state decode so it tracks state_reg exactly.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_reg      <= IDLE;
         hold_cnt_reg   <= '0;
         trig_reg       <= 1'b0;
         armed_reg      <= 1'b0;
         trig_count_reg <= 16'd0;
      end else begin
         state_reg    <= state_next;
         hold_cnt_reg <= hold_cnt_next;
         trig_reg     <= trig_next;
         armed_reg    <= (state_next == ARMED);
         if (trig_next) trig_count_reg <= trig_count_reg + 16'd1;
      end
   end

   assign Trig       = trig_reg;
   assign Armed      = armed_reg;
   assign Trig_Count = trig_count_reg;

endmodule

// File: tb/tb_trigger_in_detector.sv
// Directed bench for trigger_in_detector: latency, filter, polarity, holdoff,
// disable/reset and count wrap, with hand-computed expectations.
`timescale 1ns/1ps
module tb_trigger_in_detector;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Din = 1'b0;
   logic        EN = 1'b0;
   logic        Sel = 1'b0;
   logic        Mode = 1'b0;
   logic        Arm = 1'b0;
   logic [15:0] Holdoff = 16'd0;
   logic        Trig;
   logic        Armed;
   logic [15:0] Trig_Count;

   int checks = 0;
   int errors = 0;

   trigger_in_detector #(.FILTER_LEN(4), .HOLD_W(16)) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .Din        (Din),
      .EN         (EN),
      .Sel        (Sel),
      .Mode       (Mode),
      .Arm        (Arm),
      .Holdoff    (Holdoff),
      .Trig       (Trig),
      .Armed      (Armed),
      .Trig_Count (Trig_Count)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic arm_pulse();
      Arm = 1'b1;
      tick();
      Arm = 1'b0;
   endtask

   // Edges until Trig is seen, -1 on timeout.
   task automatic wait_trig(input int max, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      for (int i = 0; i < max && !seen; i++) begin
         tick();
         n++;
         if (Trig) seen = 1'b1;
      end
      if (!seen) n = -1;
   endtask

   task automatic count_trigs(input int cycles, output int c);
      c = 0;
      repeat (cycles) begin
         tick();
         if (Trig) c++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, c, last, since, ntr;
      logic [15:0] exp_wrap [3];
      exp_wrap[0] = 16'hFFFE;
      exp_wrap[1] = 16'hFFFF;
      exp_wrap[2] = 16'h0000;

      // Reset state
      tick(); tick();
      check("rst_trig", 32'(Trig), 32'd0);
      check("rst_armed", 32'(Armed), 32'd0);
      check("rst_count", 32'(Trig_Count), 32'd0);

      // Basic single-shot rising edge
      Reset_n = 1'b1; EN = 1'b1; Sel = 1'b0; Mode = 1'b0;
      tick();
      check("idle_no_arm", 32'(Armed), 32'd0);
      arm_pulse();
      check("armed_after_arm", 32'(Armed), 32'd1);
      Din = 1'b1;
      wait_trig(20, n);
      check("single_latency", 32'(n), 32'd7);
      check("single_count", 32'(Trig_Count), 32'd1);
      check("single_disarm", 32'(Armed), 32'd0);
      tick();
      check("single_one_cycle", 32'(Trig), 32'd0);

      // Glitch filter: 3-cycle pulse rejected, 4-cycle pulse accepted
      arm_pulse();
      check("glitch_armed", 32'(Armed), 32'd1);
      Din = 1'b0;
      count_trigs(12, c);
      check("glitch_fall_ignored", 32'(c), 32'd0);
      Din = 1'b1; repeat (3) tick(); Din = 1'b0;
      count_trigs(15, c);
      check("glitch_3cyc", 32'(c), 32'd0);
      Din = 1'b1; repeat (4) tick(); Din = 1'b0;
      count_trigs(20, c);
      check("glitch_4cyc", 32'(c), 32'd1);
      check("glitch_count", 32'(Trig_Count), 32'd2);

      // Falling-edge polarity
      Sel = 1'b1; Din = 1'b1;
      count_trigs(12, c);
      check("fall_idle_none", 32'(c), 32'd0);
      arm_pulse();
      Din = 1'b0;
      wait_trig(20, n);
      check("fall_latency", 32'(n), 32'd7);
      check("fall_count", 32'(Trig_Count), 32'd3);
      arm_pulse();
      Din = 1'b1;
      count_trigs(15, c);
      check("fall_rise_ignored", 32'(c), 32'd0);
      check("fall_still_armed", 32'(Armed), 32'd1);

      // Continuous mode, Holdoff=10, Din toggling every 4 cycles
      Sel = 1'b0; Mode = 1'b1; Holdoff = 16'd10;
      last = -1; since = 100; ntr = 0;
      for (int i = 0; i < 120; i++) begin
         Din = (i < 100) ? 1'((i / 4) % 2) : 1'b0;
         tick();
         if (Trig) begin
            ntr++;
            if (last >= 0) check("cont_gap", 32'(i - last), 32'd16);
            check("cont_armed_at_trig", 32'(Armed), 32'd0);
            last = i;
            since = 0;
         end else begin
            since++;
            if (since <= 10) check("cont_holdoff_low", 32'(Armed), 32'd0);
            else if (since == 11) check("cont_rearm", 32'(Armed), 32'd1);
         end
      end
      check("cont_trigs", 32'(ntr), 32'd6);
      check("cont_count", 32'(Trig_Count), 32'd9);

      // Disable during HOLDOFF, then asynchronous reset
      Holdoff = 16'd1000;
      Din = 1'b1;
      wait_trig(20, n);
      check("dis_latency", 32'(n), 32'd7);
      check("dis_count", 32'(Trig_Count), 32'd10);
      repeat (3) tick();
      check("dis_in_holdoff", 32'(Armed), 32'd0);
      EN = 1'b0;
      tick();
      check("dis_trig", 32'(Trig), 32'd0);
      check("dis_armed", 32'(Armed), 32'd0);
      EN = 1'b1;
      arm_pulse();
      check("dis_forced_idle", 32'(Armed), 32'd1);
      Reset_n = 1'b0;
      #1;
      check("arst_count", 32'(Trig_Count), 32'd0);
      check("arst_armed", 32'(Armed), 32'd0);
      check("arst_trig", 32'(Trig), 32'd0);
      tick();
      Reset_n = 1'b1;
      Din = 1'b0;
      count_trigs(12, c);
      Din = 1'b1;
      count_trigs(15, c);
      check("arst_no_trig", 32'(c), 32'd0);
      check("arst_needs_arm", 32'(Armed), 32'd0);
      check("arst_count_hold", 32'(Trig_Count), 32'd0);

      // Count wrap: preload the counter near the top to keep the run short
      Mode = 1'b1; Holdoff = 16'd0; Sel = 1'b0;
      arm_pulse();
      check("wrap_armed", 32'(Armed), 32'd1);
      force dut.trig_count_reg = 16'hFFFD;
      #1;
      release dut.trig_count_reg;
      check("wrap_preload", 32'(Trig_Count), 32'hFFFD);
      for (int k = 0; k < 3; k++) begin
         Din = 1'b0;
         repeat (8) tick();
         Din = 1'b1;
         wait_trig(20, n);
         check("wrap_latency", 32'(n), 32'd7);
         check("wrap_count", 32'(Trig_Count), 32'(exp_wrap[k]));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/trigger_in_detector.md
TRIGGER_IN_DETECTOR -- requirements
Module: trigger_in_detector

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, the number of consecutive agreeing samples needed to accept a level change (legal range 1..15).
REQ-002 SHALL have parameter HOLD_W, default 16, the width of the Holdoff input and of the holdoff counter.
REQ-003 SHALL have port Clock, input, 1 bit: the single system clock; all logic is on its posedge.
REQ-004 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Din, input, 1 bit: external trigger, asynchronous to Clock.
REQ-006 SHALL have port EN, input, 1 bit: block enable.
REQ-007 SHALL have port Sel, input, 1 bit: edge polarity, 0 = rising, 1 = falling.
REQ-008 SHALL have port Mode, input, 1 bit: 0 = single-shot, 1 = continuous re-arm.
REQ-009 SHALL have port Arm, input, 1 bit: arm request, sampled each cycle.
REQ-010 SHALL have port Holdoff, input, HOLD_W bits: re-arm holdoff in cycles.
REQ-011 SHALL have port Trig, output, 1 bit: registered one-cycle trigger pulse.
REQ-012 SHALL have port Armed, output, 1 bit: high while the FSM is in ARMED.
REQ-013 SHALL have port Trig_Count, output, 16 bits: number of Trig pulses issued.

Function
REQ-014 SHALL pass Din through a two-flop synchronizer (sync1, sync2).
REQ-015 SHALL update the filtered level to sync2 only after sync2 has differed from the filtered level for FILTER_LEN consecutive cycles.
- Any agreeing sample SHALL clear the filter counter.
REQ-016 SHALL detect a qualifying edge as a filtered-level change 0->1 when Sel=0, or 1->0 when Sel=1.
- Sel SHALL be sampled in the same cycle as the filtered-level change.
REQ-017 SHALL implement a three-state FSM: IDLE, ARMED, HOLDOFF.
REQ-018 In IDLE, Arm=1 with EN=1 SHALL move the FSM to ARMED on the next edge.
- A qualifying edge in the same cycle SHALL be ignored.
REQ-019 In ARMED, a qualifying edge SHALL assert Trig for exactly one cycle and increment Trig_Count.
- If Mode=0, the FSM SHALL then go to IDLE.
- If Mode=1, the FSM SHALL go to HOLDOFF, loading the counter with Holdoff.
REQ-020 In HOLDOFF, the counter SHALL decrement once per cycle.
- Qualifying edges SHALL be ignored.
- When the counter equals 0, the next state SHALL be ARMED.
- HOLDOFF therefore lasts Holdoff+1 cycles; Holdoff=0 gives 1 cycle.
REQ-021 Arm asserted in ARMED or HOLDOFF SHALL have no effect.
REQ-022 EN=0 SHALL synchronously force IDLE and Trig=0 and clear the holdoff counter.
- The synchronizer, filter and Trig_Count SHALL continue to run or hold normally.
REQ-023 Latency SHALL be exactly FILTER_LEN+3 Clock edges from a Din change (stable and set up before edge k) to Trig high after edge k+FILTER_LEN+2, given FSM in ARMED.
REQ-024 Trig_Count SHALL wrap from 16'hFFFF to 0.
REQ-025 Armed SHALL be a registered decode of state==ARMED.
REQ-026 Din pulses shorter than FILTER_LEN cycles SHALL produce no edge.

Reset
REQ-027 Reset_n=0 SHALL asynchronously set:
- State = IDLE.
- Trig = 0, Armed = 0, Trig_Count = 0.
- Holdoff counter = 0.
- sync1, sync2, filter counter and filtered level = 0.
REQ-028 Reset asserted mid-HOLDOFF or mid-filter SHALL discard all progress.
- After release, the block SHALL require a new Arm.
REQ-029 Deassertion of Reset_n SHALL take effect at the next Clock edge with no spurious Trig.

Verification
REQ-030 Bench SHALL cover the basic single-shot case, FILTER_LEN=4:
- Stimulus: EN=1, Sel=0, Mode=0, Arm pulse, then Din 0->1 held.
- Response: Trig one cycle at 7 edges after the change; Trig_Count=1; Armed=0 afterwards.
REQ-031 Bench SHALL cover continuous mode with holdoff:
- Stimulus: Mode=1, Holdoff=10, Din toggling every 4 cycles for 100 cycles.
- Response: Armed low for 11 cycles after each Trig; edges inside holdoff ignored.
REQ-032 Bench SHALL cover the glitch filter:
- Stimulus: armed, Din 3-cycle high pulse.
- Response: no Trig; a following 4-cycle pulse gives exactly one Trig.
REQ-033 Bench SHALL cover falling-edge polarity:
- Stimulus: Sel=1, Din 1->0 while armed.
- Response: Trig; a 0->1 change gives no Trig.
REQ-034 Bench SHALL cover disable and reset mid-operation:
- Stimulus: EN=0 during HOLDOFF, then Reset_n=0.
- Response: IDLE, Trig=0, Armed=0; Trig_Count=0 after reset; no Trig without a new Arm.
REQ-035 Bench SHALL cover count wrap:
- Stimulus: force 65536 triggers (Mode=1, Holdoff=0).
- Response: Trig_Count returns to 0.
